// File: rtl/reaction_sequencer.sv
// Reaction-timer round controller.
// A round runs arm -> random wait -> stimulus on -> ms reaction measurement -> result hold.
// The controller detects false starts and timeouts and tracks the best reaction time.
// A 1 ms tick is derived locally from clk50M.
//
// Ports:
//   clk50M      in   system clock
//   rst         in   asynchronous active-high reset
//   on          in   game enable (level, clk50M-synchronous); low forces IDLE
//   w           in   raw player button (asynchronous), only its synchronized rising edge is used
//   rnd[11:0]   in   LFSR value, sampled on IDLE->WAIT
//   A1          out  stimulus active (GO state)
//   LED1[9:0]   out  all bits equal A1
//   rt_ms[13:0] out  last reaction time in ms
//   best_ms     out  best valid reaction time, 16383 = none yet
//   new_best    out  one-cycle pulse on best_ms update
//   false_start out  high in FOUL
//   timeout     out  high in DONE when the round timed out
//   busy        out  high in WAIT or GO
module reaction_sequencer #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned MAX_RT_MS    = 9999
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic        on,
  input  logic        w,
  input  logic [11:0] rnd,
  output logic        A1,
  output logic [9:0]  LED1,
  output logic [13:0] rt_ms,
  output logic [13:0] best_ms,
  output logic        new_best,
  output logic        false_start,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [13:0]   MIN_DELAY = 14'(MIN_DELAY_MS);
  localparam logic [13:0]   MAX_RT    = 14'(MAX_RT_MS);
  localparam logic [13:0]   BEST_NONE = 14'h3FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_FOUL
  } state_t;

  state_t state_q, state_d;

  logic          w_meta_q, w_sync_q, w_prev_q;
  logic          press;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [13:0]   delay_q, delay_d;
  logic [13:0]   rt_cnt_q, rt_cnt_d;
  logic [13:0]   rt_inc;
  logic [13:0]   rt_ms_q, rt_ms_d;
  logic [13:0]   best_q, best_d;
  logic          new_best_q, new_best_d;
  logic          to_q, to_d;
  logic          a1_q, a1_d;
  logic          entering;

  // Button synchronizer plus edge detector.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      w_meta_q <= 1'b0;
      w_sync_q <= 1'b0;
      w_prev_q <= 1'b0;
    end else begin
      w_meta_q <= w;
      w_sync_q <= w_meta_q;
      w_prev_q <= w_sync_q;
    end
  end

  assign press = w_sync_q & ~w_prev_q;

  // The ms prescaler restarts on entry into WAIT and GO.
  // Wait and reaction times therefore count whole ticks from state entry.
  assign tick     = (presc_q == PRE_LAST);
  assign entering = ((state_d == S_WAIT) && (state_q != S_WAIT)) ||
                    ((state_d == S_GO)   && (state_q != S_GO));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (entering || tick) presc_d = '0;
  end

  // A tick coinciding with a press counts as elapsed.
  assign rt_inc = rt_cnt_q + {13'd0, tick};

  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    rt_cnt_d   = rt_cnt_q;
    rt_ms_d    = rt_ms_q;
    best_d     = best_q;
    new_best_d = 1'b0;
    to_d       = to_q;
    if (!on) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press) begin
            state_d = S_WAIT;
            delay_d = MIN_DELAY + {2'b00, rnd};
          end
        end
        S_WAIT: begin
          if (press) begin
            state_d = S_FOUL;
          end else if (tick) begin
            if (delay_q <= 14'd1) begin
              state_d  = S_GO;
              delay_d  = '0;
              rt_cnt_d = '0;
            end else begin
              delay_d = delay_q - 14'd1;
            end
          end
        end
        S_GO: begin
          rt_cnt_d = rt_inc;
          if (press || (rt_inc >= MAX_RT)) begin
            state_d = S_DONE;
            rt_ms_d = (rt_inc >= MAX_RT) ? MAX_RT : rt_inc;
            to_d    = ~press;
            if (press && (rt_inc < best_q)) begin
              best_d     = rt_inc;
              new_best_d = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (press) begin
            state_d = S_IDLE;
            to_d    = 1'b0;
          end
        end
        S_FOUL: begin
          if (press) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign a1_d = (state_d == S_GO);

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      delay_q    <= '0;
      rt_cnt_q   <= '0;
      rt_ms_q    <= '0;
      best_q     <= BEST_NONE;
      new_best_q <= 1'b0;
      to_q       <= 1'b0;
      a1_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      delay_q    <= delay_d;
      rt_cnt_q   <= rt_cnt_d;
      rt_ms_q    <= rt_ms_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
      to_q       <= to_d;
      a1_q       <= a1_d;
    end
  end

  assign A1          = a1_q;
  assign LED1        = {10{a1_q}};
  assign rt_ms       = rt_ms_q;
  assign best_ms     = best_q;
  assign new_best    = new_best_q;
  assign false_start = (state_q == S_FOUL);
  assign timeout     = (state_q == S_DONE) && to_q;
  assign busy        = (state_q == S_WAIT) || (state_q == S_GO);

endmodule

// File: doc/reaction_sequencer.md
Name: reaction_sequencer

Overview:
- Top-level round controller for the reaction-timer game. Replaces the ad-hoc toggle/enable logic with an explicit state machine.
- Each round runs: arm → random wait (seeded from the 12-bit LFSR value) → stimulus LEDs on → millisecond reaction measurement → result hold.
- Detects false starts and response timeouts, and maintains the best (lowest) reaction time for the high-score display path.
- All logic runs on clk50M. It derives its own 1 ms tick, so no clk1k domain crossing is needed.

Parameters:
- CLK_DIV, 50000: clk50M cycles per 1 ms tick.
- MIN_DELAY_MS, 1000: fixed part of the random wait, in ms.
- MAX_RT_MS, 9999: reaction timeout in ms; also the saturation value of rt_ms.

Ports:
- clk50M  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- on  input  1  game enable switch, level, synchronous to clk50M; low forces IDLE.
- w  input  1  raw player button, asynchronous, active-high.
- rnd  input  12  LFSR value, sampled once per round.
- A1  output  1  stimulus active (high in GO only).
- LED1  output  10  all bits equal to A1.
- rt_ms  output  14  last measured reaction time, binary ms.
- best_ms  output  14  best valid reaction time; 16383 means none yet.
- new_best  output  1  one-cycle pulse when best_ms updates.
- false_start  output  1  high in FOUL.
- timeout  output  1  high in DONE when the round timed out.
- busy  output  1  high in WAIT or GO.

Behaviour:
- Reset (async, rst=1): state=IDLE, A1=0, LED1=0, rt_ms=0, best_ms=16383, new_best=0, prescaler=0, counters=0.
- Button path:
  - w passes through a 2-flop synchronizer.
  - press = rising edge of the synchronized signal, one cycle wide, 3 clk50M after the w rise is first sampled.
  - The level of w is never used, only press.
- ms tick:
  - Prescaler counts 0..CLK_DIV-1.
  - tick=1 in the cycle the count equals CLK_DIV-1.
  - Prescaler clears to 0 on every entry into WAIT and GO.
- on=0 has priority over every other condition:
  - Next state is IDLE; A1/LED1 go 0 the next cycle.
  - rt_ms and best_ms are held.
- States:
  - IDLE:
    - press & on → WAIT.
    - On that transition, delay_cnt = MIN_DELAY_MS + rnd, width 14, max 1000+4095=5095.
  - WAIT:
    - press → FOUL (a press has priority over a coincident expiry).
    - Otherwise tick decrements delay_cnt.
    - On the tick that decrements delay_cnt to 0 → GO with rt_cnt=0.
  - GO:
    - A1=LED1=all ones, registered, asserted the first cycle in GO.
    - tick increments rt_cnt.
    - press → DONE with rt_ms=rt_cnt.
    - If rt_cnt reaches MAX_RT_MS before a press → DONE with rt_ms=MAX_RT_MS and timeout=1.
    - A press and reaching MAX in the same cycle counts as a press (timeout=0, rt_ms=MAX_RT_MS).
  - DONE:
    - Holds rt_ms.
    - press → IDLE; the next press then starts a new round.
  - FOUL:
    - false_start=1, rt_ms unchanged.
    - press → IDLE.
- Best score:
  - On a GO→DONE transition with timeout=0 and rt_cnt < best_ms, best_ms = rt_cnt and new_best pulses 1 cycle.
  - Ties do not update.
  - Timeouts and fouls never update.
- Measurement resolution: rt_ms is the number of full ticks elapsed between GO entry and press (truncating, error < 1 ms plus 3-cycle sync latency).
- rnd is sampled only on the IDLE→WAIT transition; later changes to rnd have no effect on the round.
- rst asserted mid-round: immediate return to the reset values above, including best_ms.

Test Plan:
Bench uses CLK_DIV=4, MIN_DELAY_MS=2, MAX_RT_MS=20.
- Reset/idle: assert rst, check all reset values; release; no press for 100 cycles → state IDLE, A1=0, LED1=0, best_ms=16383.
- Normal round: rnd=3; press in IDLE → A1 rises after exactly 5 ticks (20 cycles ±1 from WAIT entry); press after 7 ticks of GO → rt_ms=7, best_ms=7, new_best one pulse, A1=0.
- Best tracking: second round rt 9 → best stays 7, no new_best; third round rt 4 → best_ms=4 with pulse; a round with rt 4 again → no update (tie).
- False start: rnd=10; press 3 ticks into WAIT → FOUL, false_start=1, A1 never rises, rt_ms and best_ms unchanged; press → IDLE.
- Timeout: no press in GO → after 20 ticks DONE, rt_ms=20, timeout=1, best unchanged. Also press coincident with reaching MAX → timeout=0, rt_ms=20.
- Disable/reset mid-round: drop on during GO → A1=0 next cycle, IDLE, best preserved. Then assert rst during WAIT → async return to reset values, including best_ms=16383.
